// File: rtl/cr16_mem_pkg.sv
// Shared types and helpers for the CR16 byte-enable dual-port RAM.
// Words up to MAX_W bits with up to MAX_L lanes are supported by merge().
package cr16_mem_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int MAX_W = 64;
    localparam int MAX_L = 8;

    function automatic int lanes_of(input int dw, input int lw);
        return dw / lw;
    endfunction

    function automatic int aw_of(input int size);
        return $clog2(size);
    endfunction

    // Lanes with be=1 come from new_w, the rest keep old_w.
    function automatic logic [MAX_W-1:0] merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_L-1:0] be,
        input int               lane_w
    );
        logic [MAX_W-1:0] m;
        int               li;
        m = '0;
        for (int b = 0; b < MAX_W; b++) begin
            li = b / lane_w;
            if (li < MAX_L) m[b] = be[li[2:0]];
        end
        return (old_w & ~m) | (new_w & m);
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then holds READY.
module dpram_clear_seq
    import cr16_mem_pkg::*;
#(
    parameter int SIZE = 1024,
    parameter int AW   = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          ready,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr
);

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        clear_we = 1'b0;
        ready    = 1'b0;
        unique case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (cnt == AW'(SIZE - 1)) state_n = READY;
                else                      cnt_n   = cnt + AW'(1);
            end
            READY: ready = 1'b1;
        endcase
    end

    assign clear_addr = cnt;

endmodule

// File: rtl/cr16_dpram_be.sv
// CR16 dual-port RAM with lane enables, write-first collisions and clear.
// DPRAM_OUT_REG_EN adds a second output register stage (latency 2).
module cr16_dpram_be
    import cr16_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SIZE        = 1024,
    parameter int                    LANE_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int LANES = lanes_of(DATA_WIDTH, LANE_WIDTH),
    localparam int AW    = aw_of(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic                  en1,
    input  logic                  en2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [LANES-1:0]      be1,
    input  logic [LANES-1:0]      be2,
    input  logic [AW-1:0]         addr1,
    input  logic [AW-1:0]         addr2,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    input  logic [DATA_WIDTH-1:0] wr_data2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_valid1,
    output logic                  rd_valid2
);

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] o,
        input logic [DATA_WIDTH-1:0] n,
        input logic [LANES-1:0]      be
    );
        return DATA_WIDTH'(merge(MAX_W'(o), MAX_W'(n),
                                 MAX_L'(be), LANE_WIDTH));
    endfunction

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic                  clear_we;
    logic [AW-1:0]         clear_addr;
    logic                  act1, act2, wr1, wr2, same;
    logic [DATA_WIDTH-1:0] cur1, cur2, solo1, solo2, both;
    logic [DATA_WIDTH-1:0] ret1, ret2;

    dpram_clear_seq #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_clear (
        .clk        (clk),
        .reset_n    (reset_n),
        .ready      (ready),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign act1 = ready & en1;
    assign act2 = ready & en2;
    assign wr1  = act1 & we1;
    assign wr2  = act2 & we2;
    assign same = act1 & act2 & (addr1 == addr2);

    assign cur1  = mem[addr1];
    assign cur2  = mem[addr2];
    assign solo1 = wr1 ? lane_merge(cur1, wr_data1, be1) : cur1;
    assign solo2 = wr2 ? lane_merge(cur2, wr_data2, be2) : cur2;
    // On a shared address port 1 is layered last so its lanes win.
    assign both  = wr1 ? lane_merge(solo2, wr_data1, be1) : solo2;
    assign ret1  = same ? both : solo1;
    assign ret2  = same ? both : solo2;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= CLEAR_VALUE;
        end else begin
            if (wr2) mem[addr2] <= ret2;
            if (wr1) mem[addr1] <= ret1;
        end
    end

    logic                  v1_q, v2_q;
    logic [DATA_WIDTH-1:0] d1_q, d2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            v1_q <= act1;
            v2_q <= act2;
            if (act1) d1_q <= ret1;
            if (act2) d2_q <= ret2;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic                  v1_qq, v2_qq;
    logic [DATA_WIDTH-1:0] d1_qq, d2_qq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_qq <= 1'b0;
            v2_qq <= 1'b0;
            d1_qq <= '0;
            d2_qq <= '0;
        end else begin
            v1_qq <= v1_q;
            v2_qq <= v2_q;
            if (v1_q) d1_qq <= d1_q;
            if (v2_q) d2_qq <= d2_q;
        end
    end

    assign rd_valid1 = v1_qq;
    assign rd_valid2 = v2_qq;
    assign rd_data1  = d1_qq;
    assign rd_data2  = d2_qq;
`else
    assign rd_valid1 = v1_q;
    assign rd_valid2 = v2_q;
    assign rd_data1  = d1_q;
    assign rd_data2  = d2_q;
`endif

endmodule

// File: tb/tb_cr16_dpram_be.sv
// Directed bench for cr16_dpram_be (SIZE=16) against a lane-level model.
module tb_cr16_dpram_be;

    localparam int SZ = 16;
`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic        en1, en2, we1, we2;
    logic [1:0]  be1, be2;
    logic [3:0]  addr1, addr2;
    logic [15:0] wd1, wd2, rd1, rd2;
    logic        v1, v2;

    always #5 clk = ~clk;

    cr16_dpram_be #(
        .DATA_WIDTH  (16),
        .SIZE        (SZ),
        .LANE_WIDTH  (8),
        .CLEAR_VALUE (16'h0000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ready     (ready),
        .en1       (en1),
        .en2       (en2),
        .we1       (we1),
        .we2       (we2),
        .be1       (be1),
        .be2       (be2),
        .addr1     (addr1),
        .addr2     (addr2),
        .wr_data1  (wd1),
        .wr_data2  (wd2),
        .rd_data1  (rd1),
        .rd_data2  (rd2),
        .rd_valid1 (v1),
        .rd_valid2 (v2)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(input string nm,
                                  input logic [15:0] got,
                                  input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endfunction

    // Behavioural model: word array, clear countdown, output delay line.
    typedef struct packed {
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
    } rsp_t;

    logic [15:0] mm [SZ];
    int          edges = 0;
    rsp_t        dl = '0;
    logic        ev1 = 1'b0, ev2 = 1'b0;
    logic [15:0] ed1 = 16'h0, ed2 = 16'h0;

    function automatic logic [15:0] apply(input logic [15:0] w,
                                          input logic [15:0] d,
                                          input logic [1:0]  be);
        for (int i = 0; i < 2; i++)
            if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
        return w;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        rsp_t        r;
        rsp_t        o;
        logic [15:0] w;
        r = '0;
        if (!reset_n) begin
            edges = 0;
            dl    = '0;
            ev1   = 1'b0;
            ev2   = 1'b0;
            ed1   = 16'h0;
            ed2   = 16'h0;
        end else begin
            if (edges < SZ) begin
                mm[edges] = 16'h0;
                edges++;
            end else if (en1 && en2 && addr1 == addr2) begin
                w = mm[addr1];
                if (we2) w = apply(w, wd2, be2);
                if (we1) w = apply(w, wd1, be1);
                mm[addr1] = w;
                r = {1'b1, w, 1'b1, w};
            end else begin
                if (en1) begin
                    w = mm[addr1];
                    if (we1) w = apply(w, wd1, be1);
                    mm[addr1] = w;
                    r.v1 = 1'b1;
                    r.d1 = w;
                end
                if (en2) begin
                    w = mm[addr2];
                    if (we2) w = apply(w, wd2, be2);
                    mm[addr2] = w;
                    r.v2 = 1'b1;
                    r.d2 = w;
                end
            end
            if (LAT == 2) begin
                o  = dl;
                dl = r;
            end else begin
                o = r;
            end
            ev1 = o.v1;
            ev2 = o.v2;
            if (o.v1) ed1 = o.d1;
            if (o.v2) ed2 = o.d2;
        end
    end

    always @(negedge clk) begin
        check("ready", {15'b0, ready}, {15'b0, edges >= SZ});
        check("rd_valid1", {15'b0, v1}, {15'b0, ev1});
        check("rd_valid2", {15'b0, v2}, {15'b0, ev2});
        check("rd_data1", rd1, ed1);
        check("rd_data2", rd2, ed2);
    end

    task automatic op(
        input logic e1, input logic w1, input logic [1:0] b1,
        input logic [3:0] a1, input logic [15:0] d1,
        input logic e2, input logic w2, input logic [1:0] b2,
        input logic [3:0] a2, input logic [15:0] d2
    );
        en1 = e1; we1 = w1; be1 = b1; addr1 = a1; wd1 = d1;
        en2 = e2; we2 = w2; be2 = b2; addr2 = a2; wd2 = d2;
        @(negedge clk);
        en1 = 1'b0;
        en2 = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    initial begin
        en1 = 0; en2 = 0; we1 = 0; we2 = 0;
        be1 = 0; be2 = 0; addr1 = 0; addr2 = 0;
        wd1 = 0; wd2 = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        // Write request held through clear must be ignored.
        en1 = 1; we1 = 1; be1 = 2'b11; addr1 = 4'd3; wd1 = 16'hBEEF;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ready", {15'b0, ready}, 16'h0);
        check("midrst_valid1", {15'b0, v1}, 16'h0);
        check("midrst_data1", rd1, 16'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (12) @(negedge clk);
        en1 = 0;
        repeat (3) @(negedge clk);
        check("ready_edge15", {15'b0, ready}, 16'h0);
        @(negedge clk);
        check("ready_edge16", {15'b0, ready}, 16'h1);

        op(1, 0, 2'b00, 4'd7, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
        check("rd7_data", rd1, 16'h0000);
        check("rd7_valid", {15'b0, v1}, 16'h1);
        op(1, 0, 2'b00, 4'd3, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
        check("rd3_cleared", rd1, 16'h0000);

        op(1, 1, 2'b11, 4'd5, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0);
        check("be_wr_full", rd1, 16'h1234);
        op(1, 1, 2'b01, 4'd5, 16'hABCD, 0, 0, 2'b00, 4'd0, 16'h0);
        check("be_wr_low", rd1, 16'h12CD);
        op(1, 0, 2'b00, 4'd5, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
        check("be_rd", rd1, 16'h12CD);
        op(0, 0, 2'b00, 4'd0, 16'h0, 1, 1, 2'b00, 4'd5, 16'hFFFF);
        check("be_zero", rd2, 16'h12CD);

        op(1, 1, 2'b11, 4'd9, 16'h1111, 1, 1, 2'b10, 4'd9, 16'h2222);
        check("ww_p1", rd1, 16'h1111);
        check("ww_p2", rd2, 16'h1111);
        op(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd9, 16'h0);
        check("ww_rd", rd2, 16'h1111);

        op(1, 1, 2'b01, 4'd11, 16'h00AA, 1, 1, 2'b11, 4'd11, 16'hBBCC);
        check("ww_split1", rd1, 16'hBBAA);
        check("ww_split2", rd2, 16'hBBAA);

        op(1, 0, 2'b00, 4'd2, 16'h0, 1, 1, 2'b11, 4'd2, 16'h5A5A);
        check("wr_rd_p1", rd1, 16'h5A5A);
        check("wr_rd_p2", rd2, 16'h5A5A);

        op(1, 1, 2'b10, 4'd10, 16'hA0A0, 1, 0, 2'b00, 4'd5, 16'h0);
        check("indep_p1", rd1, 16'hA000);
        check("indep_p2", rd2, 16'h12CD);

        for (int i = 0; i < SZ; i++) begin
            en1 = 1; we1 = 0; addr1 = i[3:0];
            en2 = 1; we2 = 0; addr2 = 4'(SZ - 1 - i);
            @(negedge clk);
        end
        en1 = 0;
        en2 = 0;
        repeat (3) @(negedge clk);
        check("hold_valid1", {15'b0, v1}, 16'h0);
        check("hold_data1", rd1, 16'h0000);
        check("hold_data2", rd2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
